microroc_readout_emu: RTL
=========================

// Module: microroc_readout_emu
// PURPOSE
//  Transmit-side model of the Microroc RAM readout port: emulates ASIC DOUTB/TRANSMITONB/END_READOUT.
//  On START_READOUT it serializes N synthetic 160-bit frames, then pulses END_READOUT.
//  Sits in the FPGA loopback path in place of the ASIC pins.
//  Exercises the DAQ controller, redundancy mux and RAM readout deserializer without silicon.
// PARAMETERS
//  FRAME_BITS  160  bits per frame; fixed layout below, must stay 160
//  GAP_CYCLES  4    idle Clk cycles (TRANSMITONB=1) before each frame, >=1
//  END_PULSE   2    END_READOUT high width in Clk cycles, >=1
// PORTS
//  Clk          in   1   40 MHz system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  StartReadout in   1   readout request, active high; rising edge starts a readout
//  FrameCount   in   8   frames to send (0..255), latched at start
//  BcidStart    in   24  BCID of first frame, latched at start
//  Header       in   8   chip header, latched at start
//  DataPattern  in   8   channel-data seed, latched at start
//  DOUTB        out  1   serial data, active low (line = ~bit)
//  TRANSMITONB  out  1   low while a frame bit is on DOUTB
//  END_READOUT  out  1   end-of-readout pulse, active high
//  Busy         out  1   high from accepted start until return to IDLE
// BEHAVIOUR
//  Reset: DOUTB=1, TRANSMITONB=1, END_READOUT=0, Busy=0, FSM=IDLE, edge-detect reg=0, counters=0.
//  Start: rising edge = StartReadout & ~StartReadout_d (registered).
//   - Accepted only in IDLE; edges while Busy are ignored, with no queueing.
//  Latch: FrameCount, BcidStart, Header, DataPattern are captured on the accepting edge.
//   - Input changes mid-readout have no effect.
//  FSM IDLE -> (start, FrameCount!=0) GAP; (start, FrameCount==0) END.
//   - Busy=1 from the cycle after the accepting edge.
//  GAP: TRANSMITONB=1, DOUTB=1 for GAP_CYCLES cycles -> SHIFT.
//  SHIFT: FRAME_BITS consecutive cycles. TRANSMITONB=0; DOUTB=~frame[bit], MSB first (bit 159 first).
//   - After the last bit: frame_idx++.
//   - If frame_idx==FrameCount -> END, else -> GAP.
//  Frame layout: frame = {BCID[23:0], DATA[127:0], Header[7:0]}.
//   - BCID = BcidStart + frame_idx, modulo 2^24; wraps FFFFFF->000000.
//   - DATA = {16{DataPattern ^ frame_idx[7:0]}}.
//   - Frame is built combinationally from the latched values; its MSB is on the pins in the first SHIFT cycle.
//  END: END_READOUT=1 for END_PULSE cycles, TRANSMITONB=1, DOUTB=1 -> IDLE.
//   - Busy drops in the IDLE entry cycle.
//  Latency: accepting edge at cycle 0; first TRANSMITONB=0 at cycle 1+GAP_CYCLES.
//   - Total Busy = N*(GAP_CYCLES+FRAME_BITS) + END_PULSE + 1 cycles.
//  TRANSMITONB is never low for more than FRAME_BITS consecutive cycles.
//   - Between frames it is high for exactly GAP_CYCLES cycles.
//  Reset mid-operation: all outputs take reset values at the next edge; no END_READOUT is emitted.
//  StartReadout held high: counts as a single start; a new rising edge is needed after IDLE.
//  frame_idx is 8 bits; FrameCount=255 ends after frame index 254, so no overflow.
// TESTING
//  Reset check: reset=1 for 3 cycles -> DOUTB=1, TRANSMITONB=1, END_READOUT=0, Busy=0.
//  Single frame: FrameCount=1, BcidStart=24'h000010, Header=8'hA5, DataPattern=8'h3C.
//   -> one 160-cycle TRANSMITONB low window.
//   -> deserialized frame = {24'h000010, {16{8'h3C}}, 8'hA5}.
//   -> END_READOUT high for 2 cycles; Busy width 167 cycles.
//  Multi-frame: FrameCount=3, BcidStart=24'hFFFFFE.
//   -> BCIDs FFFFFE, FFFFFF, 000000.
//   -> DATA bytes 3C, 3D, 3E; exactly 4 idle cycles between frames.
//  Zero frames: FrameCount=0 -> TRANSMITONB stays 1; END_READOUT pulses 2 cycles, 1 cycle after start.
//  Busy restart: second StartReadout edge mid-frame 2 of 3 -> ignored, still 3 frames and one END pulse.
//   - Then a new edge after IDLE starts a fresh readout.
//  Reset abort: assert reset at bit 80 of frame 1.
//   -> next cycle TRANSMITONB=1, Busy=0, no END_READOUT.
//   -> a subsequent start sends from BcidStart again.

Source files
------------

// File: rtl/microroc_readout_emu.sv
`default_nettype none
// ============================================================================
//  Module   : microroc_readout_emu
//  Purpose  : Transmit-side model of the Microroc RAM readout port. On a
//             StartReadout rising edge it serializes FrameCount synthetic
//             160-bit frames on DOUTB/TRANSMITONB, then pulses END_READOUT.
//             Replaces the ASIC pins in the FPGA loopback path.
//  Ports    : Clk          - 40 MHz system clock, rising edge
//             reset        - synchronous active-high reset
//             StartReadout - readout request, rising edge starts a readout
//             FrameCount   - frames to send (0..255), latched at start
//             BcidStart    - BCID of first frame, latched at start
//             Header       - chip header byte, latched at start
//             DataPattern  - channel-data seed, latched at start
//             DOUTB        - serial data, active low (line = ~bit)
//             TRANSMITONB  - low while a frame bit is on DOUTB
//             END_READOUT  - end-of-readout pulse, active high
//             Busy         - high from accepted start until back in idle
//  Revision : 1.0 - initial release
// ============================================================================
module microroc_readout_emu #(
   parameter int FRAME_BITS = 160,
   parameter int GAP_CYCLES = 4,
   parameter int END_PULSE  = 2
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        StartReadout,
   input  logic [7:0]  FrameCount,
   input  logic [23:0] BcidStart,
   input  logic [7:0]  Header,
   input  logic [7:0]  DataPattern,
   output logic        DOUTB,
   output logic        TRANSMITONB,
   output logic        END_READOUT,
   output logic        Busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_END   = 2'd3
   } state_t;

   localparam logic [15:0] c_gap_last  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] c_bits_last = 16'(FRAME_BITS - 1);
   localparam logic [15:0] c_end_last  = 16'(END_PULSE - 1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_start_d;
   logic                    w_accept;
   logic [7:0]              r_frame_count;
   logic [23:0]             r_bcid_start;
   logic [7:0]              r_header;
   logic [7:0]              r_pattern;
   logic [7:0]              r_frame_idx;
   logic [7:0]              w_idx_next;
   logic                    w_last_frame;
   logic [15:0]             r_cnt;
   logic                    r_busy;
   logic [23:0]             w_bcid;
   logic [7:0]              w_data_byte;
   logic [FRAME_BITS-1:0]   w_frame;
   logic [7:0]              w_bit_pos;

   // Only a fresh rising edge seen in idle starts a readout; edges while
   // busy are simply dropped.
   assign w_accept     = StartReadout & ~r_start_d & (r_state == ST_IDLE);
   assign w_idx_next   = r_frame_idx + 8'd1;
   assign w_last_frame = (w_idx_next == r_frame_count);

   // Frame content derives purely from latched values and the frame index,
   // so the pins never see mid-readout input changes.
   assign w_bcid      = r_bcid_start + {16'd0, r_frame_idx};
   assign w_data_byte = r_pattern ^ r_frame_idx;
   assign w_frame     = {w_bcid, {16{w_data_byte}}, r_header};
   // MSB first: shift cycle 0 presents bit FRAME_BITS-1.
   assign w_bit_pos   = 8'(FRAME_BITS - 1) - r_cnt[7:0];

   // State register
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = (FrameCount != 8'd0) ? ST_GAP : ST_END;
            end
         end
         ST_GAP: begin
            if (r_cnt == c_gap_last) begin
               w_next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == c_bits_last) begin
               w_next_state = w_last_frame ? ST_END : ST_GAP;
            end
         end
         ST_END: begin
            if (r_cnt == c_end_last) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Datapath: edge detect, latches, phase counter, frame index, busy flag
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_start_d     <= 1'b0;
         r_frame_count <= 8'd0;
         r_bcid_start  <= 24'd0;
         r_header      <= 8'd0;
         r_pattern     <= 8'd0;
         r_frame_idx   <= 8'd0;
         r_cnt         <= 16'd0;
         r_busy        <= 1'b0;
      end else begin
         r_start_d <= StartReadout;
         // Busy lags the state by one cycle on the way out, so it stays high
         // through the idle entry cycle.
         r_busy    <= (r_state != ST_IDLE) | w_accept;

         // Phase counter restarts on every state change and rests at 0 in idle.
         if ((w_next_state != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end

         if (w_accept) begin
            r_frame_count <= FrameCount;
            r_bcid_start  <= BcidStart;
            r_header      <= Header;
            r_pattern     <= DataPattern;
            r_frame_idx   <= 8'd0;
         end else if ((r_state == ST_SHIFT) && (r_cnt == c_bits_last)) begin
            r_frame_idx <= w_idx_next;
         end
      end
   end

   // Pin outputs decode directly from state so a reset clears them at the
   // very next edge.
   assign TRANSMITONB = (r_state != ST_SHIFT);
   assign DOUTB       = (r_state == ST_SHIFT) ? ~w_frame[w_bit_pos] : 1'b1;
   assign END_READOUT = (r_state == ST_END);
   assign Busy        = r_busy;

endmodule
`default_nettype wire
